// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master, MSB first, one full-duplex frame per start.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS
);

    localparam int DIV_MAX_A = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int DIV_MAX_B = (SS_HOLD > IDLE_GAP) ? SS_HOLD : IDLE_GAP;
    localparam int DIV_MAX   = (DIV_MAX_A > DIV_MAX_B) ? DIV_MAX_A : DIV_MAX_B;
    localparam int DIV_W     = $clog2(DIV_MAX);
    localparam int BIT_W     = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] C_HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_SETUP_LAST = DIV_W'(SS_SETUP - 1);
    localparam logic [DIV_W-1:0] C_HOLD_LAST  = DIV_W'(SS_HOLD - 1);
    localparam logic [DIV_W-1:0] C_GAP_LAST   = DIV_W'(IDLE_GAP - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              state,     state_next;
    logic [DIV_W-1:0]    div_cnt,   div_next;
    logic [BIT_W-1:0]    bit_cnt,   bit_next;
    logic [DATA_W-1:0]   tx_shift,  tx_shift_next;
    logic [DATA_W-1:0]   rx_shift,  rx_shift_next;
    logic [DATA_W-1:0]   rx_reg,    rx_next;
    logic                sclk_reg,  sclk_next;
    logic                mosi_reg,  mosi_next;
    logic                ss_reg,    ss_next;
    logic                busy_reg,  busy_next;
    logic                done_reg,  done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_reg   <= '0;
            sclk_reg <= 1'b0;
            mosi_reg <= 1'b0;
            ss_reg   <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            tx_shift <= tx_shift_next;
            rx_shift <= rx_shift_next;
            rx_reg   <= rx_next;
            sclk_reg <= sclk_next;
            mosi_reg <= mosi_next;
            ss_reg   <= ss_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        div_next      = div_cnt;
        bit_next      = bit_cnt;
        tx_shift_next = tx_shift;
        rx_shift_next = rx_shift;
        rx_next       = rx_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        ss_next       = ss_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_SETUP;
                    ss_next       = 1'b0;
                    busy_next     = 1'b1;
                    mosi_next     = tx_data[DATA_W-1];
                    tx_shift_next = tx_data;
                    div_next      = '0;
                    bit_next      = '0;
                end
            end
            S_SETUP: begin
                if (div_cnt == C_SETUP_LAST) begin
                    div_next   = '0;
                    sclk_next  = 1'b1;
                    state_next = S_HIGH;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                // MISO is sampled on the falling edge we are about to produce,
                // before the slave has had a chance to move to its next bit.
                if (div_cnt == C_HALF_LAST) begin
                    div_next      = '0;
                    sclk_next     = 1'b0;
                    rx_shift_next = {rx_shift[DATA_W-2:0], MISO};
                    if (bit_cnt == C_BIT_LAST) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next    = S_LOW;
                        bit_next      = bit_cnt + 1'b1;
                        mosi_next     = tx_shift[DATA_W-2];
                        tx_shift_next = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_LOW: begin
                if (div_cnt == C_HALF_LAST) begin
                    div_next   = '0;
                    sclk_next  = 1'b1;
                    state_next = S_HIGH;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (div_cnt == C_HOLD_LAST) begin
                    div_next   = '0;
                    ss_next    = 1'b1;
                    done_next  = 1'b1;
                    rx_next    = rx_shift;
                    state_next = S_GAP;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (div_cnt == C_GAP_LAST) begin
                    div_next   = '0;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = mosi_reg;
    assign SS      = ss_reg;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed bench for spi_master with a behavioural mode-0 slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int DATA_W   = 8;
    localparam int CLK_DIV  = 2;
    localparam int SS_SETUP = 1;
    localparam int SS_HOLD  = 1;
    localparam int IDLE_GAP = 1;
    // Accept edge to busy-low edge: setup, DATA_W highs and DATA_W-1 lows, hold, gap.
    localparam int BUSY_EXP = SS_SETUP + CLK_DIV * (2 * DATA_W - 1) + SS_HOLD + IDLE_GAP;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy, done, SCLK, MOSI, MISO, SS;
    logic [DATA_W-1:0] rx_data;

    logic              start_d;
    logic [DATA_W-1:0] tx_d;
    logic              busy_d, done_d, sclk_d, mosi_d, ss_d;
    logic              miso_d = 1'b0;
    logic [DATA_W-1:0] rx_d;

    int total = 0;
    int bad   = 0;

    logic [7:0] slave_word = 8'h00;
    logic [7:0] slave_sr   = 8'h00;
    bit         dec_mode   = 1'b0;

    always #5 clk = ~clk;

    spi_master #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP),
        .SS_HOLD(SS_HOLD), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
    );

    spi_master dut_d (
        .clk(clk), .rst(rst), .start(start_d), .tx_data(tx_d),
        .busy(busy_d), .done(done_d), .rx_data(rx_d),
        .SCLK(sclk_d), .MOSI(mosi_d), .MISO(miso_d), .SS(ss_d)
    );

    // Mode-0 slave: presents MSB when selected, advances on each SCLK fall.
    always @(negedge SS) begin
        slave_sr = slave_word;
        if (dec_mode) slave_word = slave_word - 8'd1;
    end
    always @(negedge SCLK) slave_sr = {slave_sr[6:0], 1'b0};
    assign MISO = slave_sr[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain frame, 1: stray start mid-frame, 2: reset after 4th rise
    task automatic frame(input logic [7:0] tx, input logic [7:0] sw, input int mode,
                         output logic [7:0] mw, output int rises, output int dones,
                         output int bcyc, output int mchg);
        logic prev_sclk, prev_mosi;
        slave_word = sw;
        tx_data    = tx;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_ss", SS, 1'b0);
        check("accept_mosi", MOSI, tx[7]);
        mw = '0; rises = 0; dones = 0; bcyc = 0; mchg = 0;
        prev_sclk = 1'b0;
        prev_mosi = MOSI;
        for (int c = 0; c < 400 && busy; c++) begin
            bcyc++;
            if (done) dones++;
            if (SCLK && !prev_sclk) begin
                rises++;
                mw = {mw[6:0], MOSI};
            end
            if (MOSI !== prev_mosi && !SS) mchg++;
            prev_sclk = SCLK;
            prev_mosi = MOSI;
            if (mode == 1 && c == 2) begin
                start   = 1'b1;
                tx_data = 8'h11;
            end
            if (mode == 1 && c == 3) start = 1'b0;
            if (mode == 2 && rises == 4 && SCLK) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_ss", SS, 1'b1);
                check("rst_sclk", SCLK, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_rx", rx_data, 8'h00);
            end else begin
                @(negedge clk);
            end
        end
        check("frame_end_busy", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] mw;
        int rises, dones, bcyc, mchg;
        int frames, ss_run, min_gap;
        bit seen_low;
        int fss, frise, lfall, ssup;
        logic ps, pss;

        rst = 1'b1; start = 1'b0; tx_data = '0; start_d = 1'b0; tx_d = '0;
        repeat (2) @(negedge clk);
        check("reset_ss", SS, 1'b1);
        check("reset_sclk", SCLK, 1'b0);
        check("reset_mosi", MOSI, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rx", rx_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        frame(8'hA5, 8'h3C, 0, mw, rises, dones, bcyc, mchg);
        check("a5_mosi", mw, 8'hA5);
        check("a5_rx", rx_data, 8'h3C);
        check("a5_rises", rises, 8);
        check("a5_dones", dones, 1);
        check("a5_busy", bcyc, BUSY_EXP);

        frame(8'h00, 8'hFF, 0, mw, rises, dones, bcyc, mchg);
        check("00_rx", rx_data, 8'hFF);
        check("00_mosi_const", mchg, 0);
        check("00_mosi", mw, 8'h00);

        frame(8'hFF, 8'h00, 0, mw, rises, dones, bcyc, mchg);
        check("ff_rx", rx_data, 8'h00);
        check("ff_mosi_const", mchg, 0);
        check("ff_mosi", mw, 8'hFF);

        frame(8'hA5, 8'h96, 1, mw, rises, dones, bcyc, mchg);
        check("stray_mosi", mw, 8'hA5);
        check("stray_rx", rx_data, 8'h96);
        check("stray_dones", dones, 1);
        check("stray_busy", bcyc, BUSY_EXP);
        @(negedge clk);
        check("stray_not_queued", busy, 1'b0);

        frame(8'hA5, 8'h3C, 2, mw, rises, dones, bcyc, mchg);
        check("rst_no_done", dones, 0);
        @(negedge clk);

        frame(8'hA5, 8'h3C, 0, mw, rises, dones, bcyc, mchg);
        check("post_rst_mosi", mw, 8'hA5);
        check("post_rst_rx", rx_data, 8'h3C);
        check("post_rst_dones", dones, 1);

        dec_mode = 1'b1; slave_word = 8'hFF; tx_data = 8'h5A; start = 1'b1;
        frames = 0; ss_run = 0; min_gap = 1000; seen_low = 1'b0;
        for (int c = 0; c < 400 && frames < 3; c++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("held_rx%0d", frames), rx_data, 8'hFF - 8'(frames));
                frames++;
            end
            if (SS) begin
                ss_run++;
            end else begin
                if (seen_low && ss_run > 0 && ss_run < min_gap) min_gap = ss_run;
                seen_low = 1'b1;
                ss_run = 0;
            end
        end
        start = 1'b0;
        dec_mode = 1'b0;
        check("held_frames", frames, 3);
        check("held_gap_ok", (min_gap >= IDLE_GAP && min_gap < 1000), 1);
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        check("held_idle", busy, 1'b0);

        tx_d = 8'hC3; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        fss = -1; frise = -1; lfall = -1; ssup = -1; ps = 1'b0; pss = 1'b1;
        for (int c = 0; c < 400 && busy_d; c++) begin
            if (!ss_d && pss && fss < 0) fss = c;
            if (sclk_d && !ps && frise < 0) frise = c;
            if (!sclk_d && ps) lfall = c;
            if (ss_d && !pss) ssup = c;
            ps = sclk_d; pss = ss_d;
            @(negedge clk);
        end
        check("def_busy_end", busy_d, 1'b0);
        check("def_setup", frise - fss, 2);
        check("def_hold", ssup - lfall, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
